// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 3-digit
// time-multiplexed 7-segment scanner with optional leading-zero blanking.
module bcd_display_scanner #(
   parameter int REFRESH_DIV = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  value,
   input  logic        load,
   input  logic        blank_lz,
   output logic        busy,
   output logic [11:0] bcd,
   output logic [6:0]  seg,
   output logic [2:0]  digit_en
);

   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [11:0] scratch_q, scratch_d;
   logic [2:0]  iter_q, iter_d;
   logic [11:0] bcd_q, bcd_d;
   logic [11:0] adj;
   logic [19:0] shifted;

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic [6:0]    seg_q, seg_d;
   logic [2:0]    den_q, den_d;
   logic [3:0]    nib;
   logic          blank;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] encode(input logic [3:0] n);
      case (n)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Handshake: load is a request sampled only in IDLE; busy is the inverse
   // of ready. A load seen while busy (including the edge busy falls) is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load) state_d = SHIFT;
         SHIFT:   if (iter_q == 3'd7) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == SHIFT);
   end

   always_comb begin
      adj     = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
      shifted = {adj[10:0], shift_q, 1'b0};
      shift_d   = shift_q;
      scratch_d = scratch_q;
      iter_d    = iter_q;
      bcd_d     = bcd_q;
      if (state_q == IDLE) begin
         if (load) begin
            shift_d   = value;
            scratch_d = 12'h000;
            iter_d    = 3'd0;
         end
      end else begin
         shift_d   = shifted[7:0];
         scratch_d = shifted[19:8];
         iter_d    = iter_q + 3'd1;
         if (iter_q == 3'd7) bcd_d = shifted[19:8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q   <= 8'h00;
         scratch_q <= 12'h000;
         iter_q    <= 3'd0;
         bcd_q     <= 12'h000;
      end else begin
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         iter_q    <= iter_d;
         bcd_q     <= bcd_d;
      end
   end

   // Scanner is free-running and always shows the latched result.
   always_comb begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
      idx_d   = idx_q;
      if (idx_q == 2'd3)            idx_d = 2'd0;
      else if (presc_q == PRESC_MAX) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
   end

   always_comb begin
      nib   = 4'hF;
      den_d = 3'b000;
      case (idx_q)
         2'd0:    begin nib = bcd_q[3:0];  den_d = 3'b001; end
         2'd1:    begin nib = bcd_q[7:4];  den_d = 3'b010; end
         2'd2:    begin nib = bcd_q[11:8]; den_d = 3'b100; end
         default: begin nib = 4'hF;        den_d = 3'b000; end
      endcase
      blank = blank_lz &&
              (((idx_q == 2'd2) && (bcd_q[11:8] == 4'd0)) ||
               ((idx_q == 2'd1) && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0)));
      seg_d = blank ? 7'h00 : encode(nib);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         idx_q   <= 2'd0;
         seg_q   <= 7'h00;
         den_q   <= 3'b000;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         den_q   <= den_d;
      end
   end

   assign bcd      = bcd_q;
   assign seg      = seg_q;
   assign digit_en = den_q;

endmodule
